// File: rtl/pll_sup_pkg.sv
// ============================================================================
// Module      : pll_sup_pkg
// Description : Shared state encoding and counter sizing for the PLL supervisor.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pll_sup_pkg;

  typedef enum logic [2:0] {
    ST_RST_PLL   = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_RUN       = 3'd3,
    ST_FAIL      = 3'd4
  } state_t;

  // One counter serves every phase, so it must hold the largest phase length.
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    m = (m > c) ? m : c;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/cdc_sync_bit.sv
// ============================================================================
// Module      : cdc_sync_bit
// Description : Multi-flop synchronizer for a single asynchronous bit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cdc_sync_bit #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic resetn,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] r_sync;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], d};
    end
  end

  assign q = r_sync[STAGES-1];

endmodule

`default_nettype wire

// File: rtl/pll_lock_supervisor.sv
// ============================================================================
// Module      : pll_lock_supervisor
// Description : Sequences rPLL reset, qualifies LOCK and gates system reset.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pll_lock_supervisor
  import pll_sup_pkg::*;
#(
  parameter int RST_CYCLES    = 16,
  parameter int LOCK_TIMEOUT  = 27000,
  parameter int STABLE_CYCLES = 2700,
  parameter int MAX_RETRIES   = 7,
  parameter int SYNC_STAGES   = 2
) (
  input  logic                               clk,
  input  logic                               resetn,
  input  logic                               pll_lock,
  input  logic                               relock_req,
  output logic                               pll_reset,
  output logic                               sys_resetn,
  output logic                               locked,
  output logic                               fail,
  output logic [$clog2(MAX_RETRIES+1)-1:0]   retry_cnt
);

  localparam int c_cnt_w   = cnt_width(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES);
  localparam int c_retry_w = $clog2(MAX_RETRIES + 1);

  localparam logic [c_cnt_w-1:0]   c_rst_last     = c_cnt_w'(RST_CYCLES - 1);
  localparam logic [c_cnt_w-1:0]   c_timeout_last = c_cnt_w'(LOCK_TIMEOUT - 1);
  localparam logic [c_cnt_w-1:0]   c_stable_last  = c_cnt_w'(STABLE_CYCLES - 1);
  localparam logic [c_retry_w-1:0] c_retry_max    = c_retry_w'(MAX_RETRIES);

  state_t               r_state;
  logic [c_cnt_w-1:0]   r_cnt;

  state_t               w_state_nxt;
  logic [c_cnt_w-1:0]   w_cnt_nxt;
  logic [c_retry_w-1:0] w_retry_nxt;
  logic                 w_attempt_fail;
  logic                 w_lock_s;

  cdc_sync_bit #(
    .STAGES (SYNC_STAGES)
  ) u_lock_sync (
    .clk    (clk),
    .resetn (resetn),
    .d      (pll_lock),
    .q      (w_lock_s)
  );

  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt + 1'b1;
    w_retry_nxt    = retry_cnt;
    w_attempt_fail = 1'b0;

    case (r_state)
      ST_RST_PLL: begin
        if (r_cnt == c_rst_last) begin
          w_state_nxt = ST_WAIT_LOCK;
          w_cnt_nxt   = '0;
        end
      end
      ST_WAIT_LOCK: begin
        if (w_lock_s) begin
          w_state_nxt = ST_STABLE;
          w_cnt_nxt   = '0;
        end else if (r_cnt == c_timeout_last) begin
          w_attempt_fail = 1'b1;
        end
      end
      ST_STABLE: begin
        // A dropout here is treated as a bounce: back to waiting, no retry spent.
        if (!w_lock_s) begin
          w_state_nxt = ST_WAIT_LOCK;
          w_cnt_nxt   = '0;
        end else if (r_cnt == c_stable_last) begin
          w_state_nxt = ST_RUN;
          w_cnt_nxt   = '0;
        end
      end
      ST_RUN: begin
        w_cnt_nxt = '0;
        if (!w_lock_s) begin
          w_attempt_fail = 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_FAIL;
        w_cnt_nxt   = '0;
      end
    endcase

    if (w_attempt_fail) begin
      w_cnt_nxt = '0;
      if (retry_cnt == c_retry_max) begin
        w_state_nxt = ST_FAIL;
      end else begin
        w_state_nxt = ST_RST_PLL;
        w_retry_nxt = retry_cnt + 1'b1;
      end
    end

    // A requested relock overrides whatever the current phase decided.
    if (relock_req && (r_state != ST_FAIL)) begin
      w_state_nxt = ST_RST_PLL;
      w_cnt_nxt   = '0;
      w_retry_nxt = retry_cnt;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state    <= ST_RST_PLL;
      r_cnt      <= '0;
      retry_cnt  <= '0;
      pll_reset  <= 1'b1;
      sys_resetn <= 1'b0;
      locked     <= 1'b0;
      fail       <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      retry_cnt  <= w_retry_nxt;
      pll_reset  <= (w_state_nxt == ST_RST_PLL) || (w_state_nxt == ST_FAIL);
      sys_resetn <= (w_state_nxt == ST_RUN);
      locked     <= (w_state_nxt == ST_RUN);
      fail       <= (w_state_nxt == ST_FAIL);
    end
  end

endmodule

`default_nettype wire
